gpu_pixel_writer: RTL and testbench

Consumer end of the rasteriser pixel stream. Takes the (x, y) coordinates emitted by the fill/line engines, together with the current draw colour, and converts each one to a linear framebuffer address. It buffers pixels in a small FIFO and issues them as single-word writes on a req/ack memory port. It sits between the GPU raster units and the framebuffer arbiter, and absorbs memory back-pressure so the raster units only ever see a simple valid/ready handshake.

---
 rtl/gpu_pixel_writer_pkg.sv | 31 +++
 rtl/gpu_pixel_fifo.sv | 60 ++++++
 rtl/gpu_pixel_writer.sv | 151 +++++++++++++++
 tb/tb_gpu_pixel_writer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pixel_writer_pkg.sv
// Shared GPU screen geometry plus the pixel-writer state type and address helper.
`ifndef GPU_DEFINITIONS_VH
`define GPU_DEFINITIONS_VH
`define WIDTH_BITS    10
`define HEIGHT_BITS   9
`define SCREEN_WIDTH  640
`define SCREEN_HEIGHT 480
`define FB_ADDR_BITS  19
`endif

package gpu_pixel_writer_pkg;

   localparam int COLOR_BITS_DEF = 8;
   localparam int FIFO_DEPTH_DEF = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } wr_state_t;

   // 640 = 512 + 128, so the row offset is two shifts and an add.
   function automatic logic [`FB_ADDR_BITS-1:0] fb_addr_640(
      input logic [`HEIGHT_BITS-1:0] y,
      input logic [`WIDTH_BITS-1:0]  x
   );
      logic [`FB_ADDR_BITS-1:0] w_y;
      w_y = `FB_ADDR_BITS'(y);
      return (w_y << 9) + (w_y << 7) + `FB_ADDR_BITS'(x);
   endfunction

endpackage

// File: rtl/gpu_pixel_fifo.sv
// Synchronous FIFO; exposes the head entry and the one behind it so the
// writer can chain requests back-to-back on an ack edge.
module gpu_pixel_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_head,
   output logic [WIDTH-1:0] o_next,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == CNT_W'(0));
   assign o_count   = r_count;
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_head    = r_mem[r_rd_ptr];
   assign o_next    = r_mem[r_rd_ptr + PTR_W'(1)];

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_wr_ptr <= PTR_W'(0);
         r_rd_ptr <= PTR_W'(0);
         r_count  <= CNT_W'(0);
      end else begin
         r_wr_ptr <= w_do_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
         r_rd_ptr <= w_do_pop  ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/gpu_pixel_writer.sv
// Rasteriser pixel sink: range-checks (x, y), queues {addr, colour} and
// drains the queue as single-word req/ack framebuffer writes.
module gpu_pixel_writer
   import gpu_pixel_writer_pkg::*;
#(
   parameter int SCREEN_WIDTH  = `SCREEN_WIDTH,
   parameter int SCREEN_HEIGHT = `SCREEN_HEIGHT,
   parameter int COLOR_BITS    = COLOR_BITS_DEF,
   parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
   parameter int ADDR_BITS     = `FB_ADDR_BITS
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic [`WIDTH_BITS-1:0]  x_i,
   input  logic [`HEIGHT_BITS-1:0] y_i,
   input  logic [COLOR_BITS-1:0]   color_i,
   input  logic                    valid_i,
   output logic                    ready_o,
   output logic                    drop_o,
   output logic                    mem_req_o,
   output logic [ADDR_BITS-1:0]    mem_addr_o,
   output logic [COLOR_BITS-1:0]   mem_data_o,
   input  logic                    mem_ack_i,
   output logic                    busy_o
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int ENT_W = ADDR_BITS + COLOR_BITS;
   localparam logic [`WIDTH_BITS-1:0]  X_LIM = `WIDTH_BITS'(SCREEN_WIDTH);
   localparam logic [`HEIGHT_BITS-1:0] Y_LIM = `HEIGHT_BITS'(SCREEN_HEIGHT);

   wr_state_t        r_state;
   wr_state_t        w_state_nxt;
   logic             r_req;
   logic             r_drop;
   logic [ADDR_BITS-1:0]  r_addr;
   logic [COLOR_BITS-1:0] r_data;

   logic             w_in_range;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   logic             w_load;
   logic             w_req_nxt;
   logic [ADDR_BITS-1:0] w_addr;
   logic [ENT_W-1:0] w_push_data;
   logic [ENT_W-1:0] w_load_data;
   logic [ENT_W-1:0] w_head;
   logic [ENT_W-1:0] w_next;
   logic             w_full;
   logic             w_empty;
   logic [CNT_W-1:0] w_count;

   if (SCREEN_WIDTH == 640) begin : g_addr_shift
      assign w_addr = ADDR_BITS'(fb_addr_640(y_i, x_i));
   end else begin : g_addr_mul
      assign w_addr = ADDR_BITS'(y_i) * ADDR_BITS'(SCREEN_WIDTH) + ADDR_BITS'(x_i);
   end

   assign w_in_range  = (x_i < X_LIM) && (y_i < Y_LIM);
   assign w_accept    = valid_i && ready_o;
   assign w_push      = w_accept && w_in_range;
   assign w_push_data = {w_addr, color_i};

   gpu_pixel_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .n_rst   (n_rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_push_data),
      .o_head  (w_head),
      .o_next  (w_next),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // The head stays queued while its request is outstanding, so it is popped only on ack.
   always_comb begin
      w_state_nxt = r_state;
      w_req_nxt   = r_req;
      w_pop       = 1'b0;
      w_load      = 1'b0;
      w_load_data = w_head;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_load      = 1'b1;
               w_req_nxt   = 1'b1;
               w_state_nxt = ST_REQ;
            end else begin
               w_req_nxt   = 1'b0;
            end
         end
         ST_REQ: begin
            if (mem_ack_i) begin
               w_pop = 1'b1;
               if (w_count > CNT_W'(1)) begin
                  w_load      = 1'b1;
                  w_load_data = w_next;
               end else if (w_push) begin
                  w_load      = 1'b1;
                  w_load_data = w_push_data;
               end else begin
                  w_req_nxt   = 1'b0;
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_req_nxt = 1'b1;
            end
         end
         default: begin
            w_req_nxt   = 1'b0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, request and the registered memory-port / drop outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= ST_IDLE;
         r_req   <= 1'b0;
         r_drop  <= 1'b0;
         r_addr  <= {ADDR_BITS{1'b0}};
         r_data  <= {COLOR_BITS{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_req   <= w_req_nxt;
         r_drop  <= w_accept && !w_in_range;
         if (w_load) begin
            r_addr <= w_load_data[ENT_W-1 -: ADDR_BITS];
            r_data <= w_load_data[COLOR_BITS-1:0];
         end else begin
            r_addr <= r_addr;
            r_data <= r_data;
         end
      end
   end

   assign ready_o    = !w_full;
   assign drop_o     = r_drop;
   assign mem_req_o  = r_req;
   assign mem_addr_o = r_addr;
   assign mem_data_o = r_data;
   assign busy_o     = !w_empty || r_req;

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Self-checking bench for gpu_pixel_writer: vector table, directed sequences
// and random traffic against a queue-based model of expected writes.
module tb_gpu_pixel_writer;

   logic                    clk = 1'b0;
   logic                    n_rst;
   logic [`WIDTH_BITS-1:0]  x_i;
   logic [`HEIGHT_BITS-1:0] y_i;
   logic [7:0]              color_i;
   logic                    valid_i;
   logic                    ready_o;
   logic                    drop_o;
   logic                    mem_req_o;
   logic [18:0]             mem_addr_o;
   logic [7:0]              mem_data_o;
   logic                    mem_ack_i;
   logic                    busy_o;

   typedef struct { int addr; int data; } wr_t;
   typedef struct { int x; int y; int c; int exp_addr; bit exp_drop; } vec_t;

   wr_t  exp_q[$];
   vec_t vt[8];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_writes = 0;
   bit   drop_pend = 1'b0;
   bit   fresh     = 1'b0;

   always #5 clk = ~clk;

   gpu_pixel_writer dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .x_i        (x_i),
      .y_i        (y_i),
      .color_i    (color_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .drop_o     (drop_o),
      .mem_req_o  (mem_req_o),
      .mem_addr_o (mem_addr_o),
      .mem_data_o (mem_data_o),
      .mem_ack_i  (mem_ack_i),
      .busy_o     (busy_o)
   );

   task automatic chk(input string name, input longint act, input longint expv);
      n_checks++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
   endtask

   // Reference model: expected writes in acceptance order; the outstanding one is the front.
   always @(negedge clk) begin : monitor
      wr_t e;
      int  pre;
      bit  pushing;
      if (!n_rst) begin
         exp_q.delete();
         drop_pend = 1'b0;
         fresh     = 1'b0;
      end else begin
         chk("ready_o", ready_o, exp_q.size() < 4);
         chk("busy_o", busy_o, exp_q.size() != 0);
         chk("drop_o", drop_o, drop_pend);
         chk("mem_req_o", mem_req_o, (exp_q.size() != 0) && !fresh);
         if (mem_req_o && exp_q.size() != 0) begin
            chk("mem_addr_o", mem_addr_o, exp_q[0].addr);
            chk("mem_data_o", mem_data_o, exp_q[0].data);
         end
         pre = exp_q.size();
         if (mem_req_o && mem_ack_i && pre != 0) begin
            void'(exp_q.pop_front());
            n_writes++;
         end
         drop_pend = 1'b0;
         pushing   = 1'b0;
         if (valid_i && ready_o) begin
            if (int'(x_i) < 640 && int'(y_i) < 480) begin
               e.addr = int'(y_i) * 640 + int'(x_i);
               e.data = int'(color_i);
               exp_q.push_back(e);
               pushing = 1'b1;
            end else begin
               drop_pend = 1'b1;
            end
         end
         fresh = pushing && (pre == 0);
      end
   end

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (busy_o && k < 200);
      chk(name, busy_o, 0);
   endtask

   task automatic set_pix(input int x, input int y, input int c);
      x_i     = `WIDTH_BITS'(x);
      y_i     = `HEIGHT_BITS'(y);
      color_i = 8'(c);
   endtask

   // Offers n pixels (row-major, rows of 'wrap') with valid held; ack_mode 0=low, 1=high, 2=toggle.
   task automatic stream(input int n, input int x0, input int y0, input int wrap,
                         input int ack_mode, input int max_cyc, output int low_cnt);
      int idx;
      int cyc;
      bit acc;
      idx = 0;
      cyc = 0;
      low_cnt = 0;
      @(posedge clk); #1;
      valid_i   = 1'b1;
      mem_ack_i = (ack_mode == 1);
      set_pix(x0, y0, 1);
      while (idx < n && cyc < max_cyc) begin
         @(negedge clk);
         acc = valid_i && ready_o;
         if (!ready_o) low_cnt++;
         @(posedge clk); #1;
         cyc++;
         if (acc) idx++;
         set_pix(x0 + idx % wrap, y0 + idx / wrap, idx * 7 + 1);
         if (ack_mode == 2) mem_ack_i = ~mem_ack_i;
         if (idx >= n) valid_i = 1'b0;
      end
      valid_i = 1'b0;
      chk("stream_accepts", idx, n);
   endtask

   initial begin
      int low;
      int w0;
      int k;

      vt[0] = '{x: 3,    y: 2,   c: 8'hA5, exp_addr: 1283,   exp_drop: 1'b0};
      vt[1] = '{x: 639,  y: 479, c: 8'h3C, exp_addr: 307199, exp_drop: 1'b0};
      vt[2] = '{x: 640,  y: 0,   c: 8'h11, exp_addr: 0,      exp_drop: 1'b1};
      vt[3] = '{x: 0,    y: 480, c: 8'h22, exp_addr: 0,      exp_drop: 1'b1};
      vt[4] = '{x: 0,    y: 0,   c: 8'hFF, exp_addr: 0,      exp_drop: 1'b0};
      vt[5] = '{x: 1023, y: 511, c: 8'h33, exp_addr: 0,      exp_drop: 1'b1};
      vt[6] = '{x: 5,    y: 5,   c: 8'h5A, exp_addr: 3205,   exp_drop: 1'b0};
      vt[7] = '{x: 0,    y: 479, c: 8'h81, exp_addr: 306560, exp_drop: 1'b0};

      n_rst = 1'b0; valid_i = 1'b0; mem_ack_i = 1'b0;
      set_pix(0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", ready_o, 1);
      chk("rst_req", mem_req_o, 0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_data", mem_data_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_drop", drop_o, 0);
      n_rst = 1'b1;

      // Single pixels from the table with ack held high.
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         set_pix(vt[i].x, vt[i].y, vt[i].c);
         valid_i   = 1'b1;
         mem_ack_i = 1'b1;
         @(posedge clk); #1;
         valid_i = 1'b0;
         @(negedge clk);
         chk("vec_drop", drop_o, vt[i].exp_drop);
         chk("vec_req_n1", mem_req_o, 0);
         if (!vt[i].exp_drop) begin
            @(negedge clk);
            chk("vec_req_n2", mem_req_o, 1);
            chk("vec_addr", mem_addr_o, vt[i].exp_addr);
            chk("vec_data", mem_data_o, vt[i].c);
            @(negedge clk);
            chk("vec_busy_after_ack", busy_o, 0);
         end else begin
            for (int j = 0; j < 3; j++) begin
               @(negedge clk);
               chk("vec_drop_noreq", mem_req_o, 0);
            end
         end
         wait_idle("vec_idle");
      end

      // 6x6 rectangle, row-major, full throughput.
      w0 = n_writes;
      stream(36, 0, 0, 6, 1, 200, low);
      chk("rect_ready_low_cycles", low, 0);
      wait_idle("rect_idle");
      chk("rect_writes", n_writes - w0, 36);

      // Back-pressure: 4 fill the FIFO, a 5th waits, then ack pulses.
      w0 = n_writes;
      stream(4, 10, 7, 100, 0, 20, low);
      @(posedge clk); #1;
      set_pix(14, 7, 8'h77);
      valid_i = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("bp_ready_low", ready_o, 0);
      end
      stream(2, 14, 7, 100, 2, 40, low);
      k = 0;
      while (busy_o && k < 100) begin
         @(posedge clk); #1;
         mem_ack_i = ~mem_ack_i;
         k++;
      end
      chk("bp_idle", busy_o, 0);
      chk("bp_writes", n_writes - w0, 6);

      // Randomised traffic with random back-pressure.
      for (int c = 0; c < 600; c++) begin
         @(posedge clk); #1;
         valid_i   = ($urandom_range(0, 2) != 0);
         mem_ack_i = ($urandom_range(0, 2) != 0);
         set_pix($urandom_range(0, 700), $urandom_range(0, 511), $urandom_range(0, 255));
      end
      @(posedge clk); #1;
      valid_i   = 1'b0;
      mem_ack_i = 1'b1;
      wait_idle("rand_idle");

      // Reset with a request outstanding and three pixels queued.
      stream(3, 20, 3, 10, 0, 10, low);
      @(negedge clk);
      chk("mr_req_before", mem_req_o, 1);
      #2;
      n_rst = 1'b0;
      #1;
      chk("mr_req", mem_req_o, 0);
      chk("mr_addr", mem_addr_o, 0);
      chk("mr_data", mem_data_o, 0);
      chk("mr_ready", ready_o, 1);
      chk("mr_busy", busy_o, 0);
      chk("mr_drop", drop_o, 0);
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b1;
      w0 = n_writes;
      set_pix(1, 1, 8'h4B);
      valid_i   = 1'b1;
      mem_ack_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mr_new_addr", mem_addr_o, 641);
      chk("mr_new_req", mem_req_o, 1);
      wait_idle("mr_idle");
      chk("mr_writes", n_writes - w0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
